seg7_step_decoder: RTL and testbench

Observer block for the seven-segment digit stream produced by the decimal up/down counter path. It samples a raw segment bus, filters glitches, decodes the pattern back to a BCD digit, and classifies each accepted change as an up-step, a down-step or an error. It sits on the receiving side of the segment interface, for self-test and for driving downstream logic from a display bus.

---
 rtl/seg7_step_decoder.sv | 152 +++++++++++++++
 tb/tb_seg7_step_decoder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_step_decoder.sv
// Seven-segment stream observer: glitch filter, BCD decode, up/down/error step classification.
// Optional net step counter built when SEG7_NET_COUNT_EN is defined; otherwise o_net is tied to 0.
module seg7_step_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] i_seg,
  output logic [3:0] o_digit,
  output logic       o_valid,
  output logic       o_step_up,
  output logic       o_step_down,
  output logic       o_error,
  output logic       o_dir,
  output logic [7:0] o_net,
  output logic       dbg_state
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [7:0] RUN_MAX  = 8'(STABLE_CYCLES);
  localparam logic [7:0] RUN_LAST = 8'(STABLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [6:0] samp_q, last_q;
  logic [7:0] run_q, run_d;
  logic       match, accept;
  logic       is_blank, is_legal;
  logic [3:0] dec;
  logic [3:0] next_up, next_dn;
  logic [3:0] digit_d;
  logic       valid_d, dir_d, up_d, down_d, err_d;

  // Stability filter: run counter saturates, so acceptance fires once per stable run.
  always_comb begin
    match  = (i_seg == samp_q);
    run_d  = 8'd0;
    if (match) begin
      run_d = (run_q < RUN_MAX) ? run_q + 8'd1 : run_q;
    end
    accept = match && (run_q == RUN_LAST) && (i_seg != last_q);
  end

  always_comb begin
    is_legal = 1'b1;
    dec      = 4'd0;
    case (i_seg)
      7'h3F: dec = 4'd0;
      7'h06: dec = 4'd1;
      7'h5B: dec = 4'd2;
      7'h4F: dec = 4'd3;
      7'h66: dec = 4'd4;
      7'h6D: dec = 4'd5;
      7'h7D: dec = 4'd6;
      7'h07: dec = 4'd7;
      7'h7F: dec = 4'd8;
      7'h6F: dec = 4'd9;
      default: is_legal = 1'b0;
    endcase
    is_blank = (i_seg == 7'h00);
  end

  assign next_up = (o_digit == 4'd9) ? 4'd0 : o_digit + 4'd1;
  assign next_dn = (o_digit == 4'd0) ? 4'd9 : o_digit - 4'd1;

  always_comb begin
    state_d = state_q;
    digit_d = o_digit;
    valid_d = o_valid;
    dir_d   = o_dir;
    up_d    = 1'b0;
    down_d  = 1'b0;
    err_d   = 1'b0;
    if (accept) begin
      if (is_blank) begin
        state_d = IDLE;
        valid_d = 1'b0;
      end else if (!is_legal) begin
        state_d = IDLE;
        valid_d = 1'b0;
        err_d   = 1'b1;
      end else if (state_q == IDLE) begin
        state_d = LOCKED;
        digit_d = dec;
        valid_d = 1'b1;
      end else begin
        digit_d = dec;
        if (dec == next_up) begin
          up_d  = 1'b1;
          dir_d = 1'b1;
        end else if (dec == next_dn) begin
          down_d = 1'b1;
          dir_d  = 1'b0;
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      samp_q      <= 7'h00;
      last_q      <= 7'h00;
      run_q       <= 8'd0;
      o_digit     <= 4'd0;
      o_valid     <= 1'b0;
      o_dir       <= 1'b0;
      o_step_up   <= 1'b0;
      o_step_down <= 1'b0;
      o_error     <= 1'b0;
    end else begin
      state_q     <= state_d;
      samp_q      <= i_seg;
      run_q       <= run_d;
      o_digit     <= digit_d;
      o_valid     <= valid_d;
      o_dir       <= dir_d;
      o_step_up   <= up_d;
      o_step_down <= down_d;
      o_error     <= err_d;
      if (accept) begin
        last_q <= i_seg;
      end
    end
  end

  assign dbg_state = state_q;

`ifdef SEG7_NET_COUNT_EN
  logic [7:0] net_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      net_q <= 8'd0;
    end else if (up_d) begin
      net_q <= net_q + 8'd1;
    end else if (down_d) begin
      net_q <= net_q - 8'd1;
    end
  end

  assign o_net = net_q;
`else
  assign o_net = 8'd0;
`endif

endmodule

// File: tb/tb_seg7_step_decoder.sv
// Randomized bench for seg7_step_decoder against a behavioural model of the observer rules.
module tb_seg7_step_decoder;

  localparam int S = 4;
  localparam int W = 18;

  logic       clk;
  logic       rst;
  logic [6:0] i_seg;
  logic [3:0] o_digit;
  logic       o_valid, o_step_up, o_step_down, o_error, o_dir;
  logic [7:0] o_net;
  logic       dbg_state;

  seg7_step_decoder #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .i_seg(i_seg),
    .o_digit(o_digit), .o_valid(o_valid),
    .o_step_up(o_step_up), .o_step_down(o_step_down), .o_error(o_error),
    .o_dir(o_dir), .o_net(o_net), .dbg_state(dbg_state)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  int n_up  = 0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // behavioural model
  int unsigned pat[10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  int m_prev, m_hold, m_last, m_digit, m_net;
  bit m_locked, m_valid, m_dir, m_up, m_dn, m_err;
  logic [W-1:0] exp_q[$];

  function automatic int decode(input int x);
    for (int i = 0; i < 10; i++) if (pat[i] == x) return i;
    return -1;
  endfunction

  task automatic model_accept(input int x);
    int d;
    d = decode(x);
    if (x == 0) begin
      m_locked = 0; m_valid = 0;
    end else if (d < 0) begin
      m_locked = 0; m_valid = 0; m_err = 1;
    end else if (!m_locked) begin
      m_locked = 1; m_digit = d; m_valid = 1;
    end else begin
      if (d == (m_digit + 1) % 10) begin
        m_up = 1; m_dir = 1; m_net = (m_net + 1) % 256;
      end else if (d == (m_digit + 9) % 10) begin
        m_dn = 1; m_dir = 0; m_net = (m_net + 255) % 256;
      end else begin
        m_err = 1;
      end
      m_digit = d;
    end
  endtask

  task automatic model_edge(input int x, input bit r);
    logic [7:0] net_e;
    m_up = 0; m_dn = 0; m_err = 0;
    if (r) begin
      m_prev = 0; m_hold = 0; m_last = 0; m_locked = 0;
      m_digit = 0; m_valid = 0; m_dir = 0; m_net = 0;
    end else begin
      // m_hold = number of edges the bus has repeated the previous sample
      if (x == m_prev) begin
        if (m_hold < S) begin
          m_hold++;
          if (m_hold == S && x != m_last) begin
            m_last = x;
            model_accept(x);
          end
        end
      end else begin
        m_hold = 0;
      end
      m_prev = x;
    end
`ifdef SEG7_NET_COUNT_EN
    net_e = 8'(m_net);
`else
    net_e = 8'd0;
`endif
    exp_q.push_back({4'(m_digit), m_valid, m_up, m_dn, m_err, m_dir, net_e, m_locked});
  endtask

  // one clock: model follows the edge, outputs compared 1 ns later
  task automatic tick();
    logic [W-1:0] e;
    @(posedge clk);
    model_edge(int'(i_seg), rst);
    #1;
    e = exp_q.pop_front();
    check("digit", 32'(o_digit), 32'(e[17:14]));
    check("valid", 32'(o_valid), 32'(e[13]));
    check("step_up", 32'(o_step_up), 32'(e[12]));
    check("step_down", 32'(o_step_down), 32'(e[11]));
    check("error", 32'(o_error), 32'(e[10]));
    check("dir", 32'(o_dir), 32'(e[9]));
    check("net", 32'(o_net), 32'(e[8:1]));
    check("state", 32'(dbg_state), 32'(e[0]));
    if (o_step_up) n_up++;
  endtask

  task automatic drive(input logic [6:0] p, input int n);
    i_seg = p;
    repeat (n) tick();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  initial begin
    int r, d, hold;
    logic [6:0] p;
    rst = 1'b1;
    i_seg = 7'h00;
    do_reset(2);
    check("reset_digit", 32'(o_digit), 32'd0);
    check("reset_valid", 32'(o_valid), 32'd0);

    // lock, then up-steps 0->1->2
    n_up = 0;
    drive(7'h3F, 6);
    check("lock_valid", 32'(o_valid), 32'd1);
    drive(7'h06, 6);
    drive(7'h5B, 6);
    check("seq_up_pulses", 32'(n_up), 32'd2);
    check("seq_digit", 32'(o_digit), 32'd2);
    check("seq_dir", 32'(o_dir), 32'd1);
`ifdef SEG7_NET_COUNT_EN
    check("seq_net", 32'(o_net), 32'd2);
`endif

    // short 3F run must not be accepted
    drive(7'h00, 6);
    drive(7'h3F, 3);
    drive(7'h06, 6);
    // wrap-around both ways
    drive(7'h3F, 6); drive(7'h6F, 6);
    check("wrap_digit", 32'(o_digit), 32'd9);
    drive(7'h3F, 6);
    // non-adjacent jump, then step
    drive(7'h4F, 6); drive(7'h7F, 6);
    check("jump_digit", 32'(o_digit), 32'd8);
    check("jump_locked", 32'(dbg_state), 32'd1);
    drive(7'h6F, 6);
    // glitch back to accepted pattern, illegal, relock
    drive(7'h06, 6); drive(7'h00, 2); drive(7'h06, 6);
    check("glitch_digit", 32'(o_digit), 32'd1);
    drive(7'h49, 6);
    check("illegal_valid", 32'(o_valid), 32'd0);
    drive(7'h5B, 6);
    // reset mid-run
    drive(7'h3F, 6); drive(7'h06, 2); do_reset(1); drive(7'h06, 7);
    check("post_reset_digit", 32'(o_digit), 32'd1);
    check("post_reset_dir", 32'(o_dir), 32'd0);

    // randomized segments
    d = 0;
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        do_reset(1);
        continue;
      end else if (r < 12) begin
        p = 7'h00;
      end else if (r < 22) begin
        p = 7'($urandom_range(0, 127));
      end else begin
        r = $urandom_range(0, 9);
        if (r < 4) d = (d + 1) % 10;
        else if (r < 8) d = (d + 9) % 10;
        else d = $urandom_range(0, 9);
        p = 7'(pat[d]);
      end
      hold = $urandom_range(1, 7);
      drive(p, hold);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
